pipelined_control_unit: RTL and testbench
=========================================

Name: pipelined_control_unit

Overview:
- Successor to the combinational decoder: decodes op/func3/func11 in ID and registers all control into an ID/EX pipeline register with a valid bit.
- Detects load-use hazards and stalls ID. Kills ID/EX on a flush from EX. Freezes on a downstream hold.
- Generalised with a parametrised ALU-control width (func11[0] selects extended ALU ops), illegal-instruction detection, and saturating stall/flush counters.

Parameters:
- REG_ADDR_W, 5: register index width.
- ALU_CTRL_W, 4: alu_control width; must be >= 4.
- EXT_ALU, 1: 1 means OP_A with func11 = 1 selects ALU op {1, func3}; 0 means any nonzero func11 is illegal.
- CNT_W, 16: width of the saturating performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- id_valid  in  1  ID holds an instruction
- id_op  in  3  opcode
- id_func3  in  3  subtype
- id_func11  in  11  prefix
- id_rd, id_rs1, id_rs2  in  REG_ADDR_W each  register fields
- ex_flush  in  1  taken jump/branch resolved in EX
- ex_hold  in  1  downstream stall; freeze ID/EX
- id_stall  out  1  ID must hold its instruction (combinational)
- id_illegal  out  1  ID instruction is illegal (combinational, qualified by id_valid)
- ex_valid  out  1  ID/EX holds a live instruction
- ex_reg_write, ex_mem_write, ex_jump, ex_jump_cond, ex_alu_src  out  1 each
- ex_jump_cond_type  out  3
- ex_alu_control  out  ALU_CTRL_W
- ex_imm_src  out  4
- ex_result_src  out  2
- ex_rd  out  REG_ADDR_W
- stall_count, flush_count  out  CNT_W each

Behaviour:
- Reset: every registered output is 0 (ex_valid = 0, counters = 0). Reset mid-operation discards the ID/EX contents immediately.
- Decode by op (A=000, B=001, C=010, D=011, F=101, G=110):
  - reg_write = 1 except for C and G.
  - mem_write = 1 only for C.
  - jump = (D with func3 = 010) or F.
  - jump_cond = 1 for G; jump_cond_type = func3.
  - alu_src = 1 for B and F.
- Per-op control values:
  - A: alu = {func11[0] & EXT_ALU, func3}, imm = 0000, res = 00.
  - B: alu = func3, imm = 0010 if func3[2] else 0000, res = 00.
  - C: alu = 0, imm = 0100, res = 00.
  - D, func3 = 000: imm = 1100, res = 11. D, func3 = 001: imm = 1110, res = 11. D, func3 = 010: imm = 1100, res = 10.
  - F: alu = 0, imm = 0000, res = 01 if func3 = 000, else 10.
  - G: alu = 1, imm = 1100, res = 00.
  - alu_control is zero-extended to ALU_CTRL_W.
- Illegal conditions:
  - op = 100 or 111.
  - D with func3 > 010.
  - F with func3 not in {000, 010}.
  - A with func11 > 1, or A with func11 = 1 when EXT_ALU = 0.
  - B, C and G with func11 != 0.
  - Illegal instructions load as a bubble; id_illegal is asserted for that cycle.
- Register sources used: A, C, G use rs1 and rs2; B and F use rs1; D uses none.
- Load-use hazard: ex_valid, and EX holds LDM (result_src = 01), and ex_rd != 0, and ex_rd matches a used source of a valid ID instruction.
  - id_stall = hazard & ~ex_flush & ~ex_hold, OR ex_hold & ~ex_flush.
- Per-cycle priority when loading ID/EX:
  1. ex_flush: load a bubble (ex_valid = 0, all write/jump enables 0); ID is not stalled.
  2. ex_hold: ID/EX unchanged.
  3. hazard: load a bubble.
  4. Otherwise: load the decoded ID instruction, with ex_valid = id_valid & ~illegal.
  - A bubble zeroes all control outputs. The datapath relies on enables only.
- Counters (saturate at all-ones, no wrap):
  - stall_count increments on each hazard-bubble cycle.
  - flush_count increments on each cycle with ex_flush = 1.
- Latency: control appears on ex_* exactly 1 cycle after the ID cycle that is accepted.

Test Plan:
- ADD (op 000, func3 000, func11 0, rd 3), no hazard -> next cycle ex_valid = 1, ex_reg_write = 1, ex_alu_control = 0000, ex_rd = 3.
- LDM rd = 5, then op 000 with rs2 = 5 -> one bubble cycle with id_stall = 1, stall_count = 1; the ADD issues the following cycle.
- LDM rd = 0, then consumer with rs1 = 0 -> no stall.
- ex_flush and hazard in the same cycle -> bubble, id_stall = 0, flush_count +1, stall_count unchanged.
- EXT_ALU = 1, op 000, func11 = 1, func3 = 011 -> ex_alu_control = 1011. op 100 -> id_illegal = 1 and ex_valid = 0.
- ex_hold high for 3 cycles with a live ID/EX entry -> ex_* stable; assert rst mid-hold -> all outputs 0 asynchronously. Drive flush_count to all-ones -> stays all-ones.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// Pipelined control unit: decodes the ID instruction, detects load-use
// hazards, and registers control into the ID/EX stage with a valid bit.
module pipelined_control_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_CTRL_W = 4,
  parameter int EXT_ALU    = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [2:0]            id_op,
  input  logic [2:0]            id_func3,
  input  logic [10:0]           id_func11,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  ex_flush,
  input  logic                  ex_hold,
  output logic                  id_stall,
  output logic                  id_illegal,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_mem_write,
  output logic                  ex_jump,
  output logic                  ex_jump_cond,
  output logic                  ex_alu_src,
  output logic [2:0]            ex_jump_cond_type,
  output logic [ALU_CTRL_W-1:0] ex_alu_control,
  output logic [3:0]            ex_imm_src,
  output logic [1:0]            ex_result_src,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  typedef enum logic [2:0] {
    OP_A = 3'b000, OP_B = 3'b001, OP_C = 3'b010, OP_D = 3'b011,
    OP_E = 3'b100, OP_F = 3'b101, OP_G = 3'b110, OP_H = 3'b111
  } op_e;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_write;
    logic                  jump;
    logic                  jump_cond;
    logic                  alu_src;
    logic [2:0]            jump_cond_type;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic [3:0]            imm_src;
    logic [1:0]            result_src;
    logic [REG_ADDR_W-1:0] rd;
  } ctrl_t;

  ctrl_t           dec;
  ctrl_t           ctrl_d, ctrl_q;
  logic            illegal, use_rs1, use_rs2, hazard;
  logic [CNT_W-1:0] stall_count_d, stall_count_q;
  logic [CNT_W-1:0] flush_count_d, flush_count_q;
  op_e             op;

  // Instruction decode, illegal detection and source-register usage
  always_comb begin
    dec                = '0;
    illegal            = 1'b0;
    use_rs1            = 1'b0;
    use_rs2            = 1'b0;
    op                 = op_e'(id_op);
    dec.rd             = id_rd;
    dec.jump_cond_type = id_func3;
    case (op)
      OP_A: begin
        dec.reg_write           = 1'b1;
        dec.alu_control[3:0]    = {id_func11[0] & (EXT_ALU != 0), id_func3};
        use_rs1                 = 1'b1;
        use_rs2                 = 1'b1;
        illegal = (id_func11[10:1] != '0) || (id_func11[0] && (EXT_ALU == 0));
      end
      OP_B: begin
        dec.reg_write        = 1'b1;
        dec.alu_src          = 1'b1;
        dec.alu_control[2:0] = id_func3;
        dec.imm_src          = id_func3[2] ? 4'b0010 : 4'b0000;
        use_rs1              = 1'b1;
        illegal              = (id_func11 != '0);
      end
      OP_C: begin
        dec.mem_write = 1'b1;
        dec.imm_src   = 4'b0100;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        illegal       = (id_func11 != '0);
      end
      OP_D: begin
        dec.reg_write = 1'b1;
        case (id_func3)
          3'b000: begin dec.imm_src = 4'b1100; dec.result_src = 2'b11; end
          3'b001: begin dec.imm_src = 4'b1110; dec.result_src = 2'b11; end
          3'b010: begin dec.imm_src = 4'b1100; dec.result_src = 2'b10; dec.jump = 1'b1; end
          default: illegal = 1'b1;
        endcase
      end
      OP_F: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = (id_func3 == 3'b000) ? 2'b01 : 2'b10;
        use_rs1        = 1'b1;
        illegal        = (id_func3 != 3'b000) && (id_func3 != 3'b010);
      end
      OP_G: begin
        dec.jump_cond   = 1'b1;
        dec.alu_control = ALU_CTRL_W'(1);
        dec.imm_src     = 4'b1100;
        use_rs1         = 1'b1;
        use_rs2         = 1'b1;
        illegal         = (id_func11 != '0);
      end
      default: illegal = 1'b1;
    endcase
  end

  assign hazard = ctrl_q.valid && (ctrl_q.result_src == 2'b01) && (ctrl_q.rd != '0) &&
                  id_valid && ((use_rs1 && (id_rs1 == ctrl_q.rd)) ||
                               (use_rs2 && (id_rs2 == ctrl_q.rd)));

  assign id_stall   = (hazard & ~ex_flush & ~ex_hold) | (ex_hold & ~ex_flush);
  assign id_illegal = id_valid & illegal;

  // ID/EX next state: flush beats hold beats hazard beats normal load
  always_comb begin
    ctrl_d        = ctrl_q;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (ex_flush) begin
      ctrl_d = '0;
      if (flush_count_q != '1) flush_count_d = flush_count_q + CNT_W'(1);
    end else if (ex_hold) begin
      ctrl_d = ctrl_q;
    end else if (hazard) begin
      ctrl_d = '0;
      if (stall_count_q != '1) stall_count_d = stall_count_q + CNT_W'(1);
    end else if (id_valid && !illegal) begin
      ctrl_d       = dec;
      ctrl_d.valid = 1'b1;
    end else begin
      ctrl_d = '0;
    end
  end

  // ID/EX register and performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q        <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      ctrl_q        <= ctrl_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign ex_valid          = ctrl_q.valid;
  assign ex_reg_write      = ctrl_q.reg_write;
  assign ex_mem_write      = ctrl_q.mem_write;
  assign ex_jump           = ctrl_q.jump;
  assign ex_jump_cond      = ctrl_q.jump_cond;
  assign ex_alu_src        = ctrl_q.alu_src;
  assign ex_jump_cond_type = ctrl_q.jump_cond_type;
  assign ex_alu_control    = ctrl_q.alu_control;
  assign ex_imm_src        = ctrl_q.imm_src;
  assign ex_result_src     = ctrl_q.result_src;
  assign ex_rd             = ctrl_q.rd;
  assign stall_count       = stall_count_q;
  assign flush_count       = flush_count_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed self-checking bench for pipelined_control_unit.
module tb_pipelined_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [2:0]  id_op, id_func3;
  logic [10:0] id_func11;
  logic [4:0]  id_rd, id_rs1, id_rs2;
  logic        ex_flush, ex_hold;
  logic        id_stall, id_illegal, ex_valid, ex_reg_write, ex_mem_write;
  logic        ex_jump, ex_jump_cond, ex_alu_src;
  logic [2:0]  ex_jump_cond_type;
  logic [3:0]  ex_alu_control, ex_imm_src;
  logic [1:0]  ex_result_src;
  logic [4:0]  ex_rd;
  logic [3:0]  stall_count, flush_count;

  int unsigned passed = 0;
  int unsigned total  = 0;

  pipelined_control_unit #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_func3(id_func3),
    .id_func11(id_func11), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_flush(ex_flush), .ex_hold(ex_hold), .id_stall(id_stall), .id_illegal(id_illegal),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_jump(ex_jump), .ex_jump_cond(ex_jump_cond), .ex_alu_src(ex_alu_src),
    .ex_jump_cond_type(ex_jump_cond_type), .ex_alu_control(ex_alu_control),
    .ex_imm_src(ex_imm_src), .ex_result_src(ex_result_src), .ex_rd(ex_rd),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] f3,
                       input logic [10:0] f11, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid = v; id_op = op; id_func3 = f3; id_func11 = f11;
    id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_flush = 1'b0; ex_hold = 1'b0;
    drive(1'b0, 3'b000, 3'b000, 11'd0, 5'd0, 5'd0, 5'd0);
    tick(); tick();
    total++; if (ex_valid !== 1'b0) $display("FAIL reset_valid got=%0h exp=0", ex_valid); else passed++;
    total++; if (ex_reg_write !== 1'b0) $display("FAIL reset_regw got=%0h exp=0", ex_reg_write); else passed++;
    total++; if (stall_count !== 4'd0) $display("FAIL reset_stall_cnt got=%0h exp=0", stall_count); else passed++;
    total++; if (flush_count !== 4'd0) $display("FAIL reset_flush_cnt got=%0h exp=0", flush_count); else passed++;
    @(negedge clk); rst = 1'b0;
    tick();
  endtask

  task automatic test_add();
    drive(1'b1, 3'b000, 3'b000, 11'd0, 5'd3, 5'd1, 5'd2);
    tick();
    total++; if (ex_valid !== 1'b1) $display("FAIL add_valid got=%0h exp=1", ex_valid); else passed++;
    total++; if (ex_reg_write !== 1'b1) $display("FAIL add_regw got=%0h exp=1", ex_reg_write); else passed++;
    total++; if (ex_alu_control !== 4'b0000) $display("FAIL add_alu got=%0h exp=0", ex_alu_control); else passed++;
    total++; if (ex_rd !== 5'd3) $display("FAIL add_rd got=%0d exp=3", ex_rd); else passed++;
    total++; if (ex_mem_write !== 1'b0) $display("FAIL add_memw got=%0h exp=0", ex_mem_write); else passed++;
  endtask

  task automatic test_load_use();
    drive(1'b1, 3'b101, 3'b000, 11'd0, 5'd5, 5'd1, 5'd0);
    tick();
    total++; if (ex_result_src !== 2'b01) $display("FAIL ldm_res got=%0h exp=1", ex_result_src); else passed++;
    drive(1'b1, 3'b000, 3'b000, 11'd0, 5'd7, 5'd1, 5'd5);
    #1;
    total++; if (id_stall !== 1'b1) $display("FAIL lu_stall got=%0h exp=1", id_stall); else passed++;
    tick();
    total++; if (ex_valid !== 1'b0) $display("FAIL lu_bubble got=%0h exp=0", ex_valid); else passed++;
    total++; if (stall_count !== 4'd1) $display("FAIL lu_stall_cnt got=%0d exp=1", stall_count); else passed++;
    total++; if (id_stall !== 1'b0) $display("FAIL lu_release got=%0h exp=0", id_stall); else passed++;
    tick();
    total++; if (ex_valid !== 1'b1) $display("FAIL lu_issue_valid got=%0h exp=1", ex_valid); else passed++;
    total++; if (ex_rd !== 5'd7) $display("FAIL lu_issue_rd got=%0d exp=7", ex_rd); else passed++;
  endtask

  task automatic test_rd_zero();
    drive(1'b1, 3'b101, 3'b000, 11'd0, 5'd0, 5'd2, 5'd0);
    tick();
    drive(1'b1, 3'b000, 3'b001, 11'd0, 5'd8, 5'd0, 5'd0);
    #1;
    total++; if (id_stall !== 1'b0) $display("FAIL rd0_stall got=%0h exp=0", id_stall); else passed++;
    tick();
    total++; if (ex_valid !== 1'b1) $display("FAIL rd0_issue got=%0h exp=1", ex_valid); else passed++;
    total++; if (stall_count !== 4'd1) $display("FAIL rd0_stall_cnt got=%0d exp=1", stall_count); else passed++;
  endtask

  task automatic test_flush_hazard();
    drive(1'b1, 3'b101, 3'b000, 11'd0, 5'd6, 5'd1, 5'd0);
    tick();
    drive(1'b1, 3'b010, 3'b000, 11'd0, 5'd0, 5'd1, 5'd6);
    ex_flush = 1'b1;
    #1;
    total++; if (id_stall !== 1'b0) $display("FAIL fh_stall got=%0h exp=0", id_stall); else passed++;
    tick();
    ex_flush = 1'b0;
    total++; if (ex_valid !== 1'b0) $display("FAIL fh_valid got=%0h exp=0", ex_valid); else passed++;
    total++; if (ex_mem_write !== 1'b0) $display("FAIL fh_memw got=%0h exp=0", ex_mem_write); else passed++;
    total++; if (flush_count !== 4'd1) $display("FAIL fh_flush_cnt got=%0d exp=1", flush_count); else passed++;
    total++; if (stall_count !== 4'd1) $display("FAIL fh_stall_cnt got=%0d exp=1", stall_count); else passed++;
  endtask

  task automatic test_ext_illegal();
    drive(1'b1, 3'b000, 3'b011, 11'd1, 5'd4, 5'd1, 5'd2);
    tick();
    total++; if (ex_alu_control !== 4'b1011) $display("FAIL ext_alu got=%0h exp=b", ex_alu_control); else passed++;
    total++; if (ex_valid !== 1'b1) $display("FAIL ext_valid got=%0h exp=1", ex_valid); else passed++;
    drive(1'b1, 3'b100, 3'b000, 11'd0, 5'd4, 5'd0, 5'd0);
    #1;
    total++; if (id_illegal !== 1'b1) $display("FAIL ill_op4 got=%0h exp=1", id_illegal); else passed++;
    tick();
    total++; if (ex_valid !== 1'b0) $display("FAIL ill_valid got=%0h exp=0", ex_valid); else passed++;
    total++; if (ex_reg_write !== 1'b0) $display("FAIL ill_regw got=%0h exp=0", ex_reg_write); else passed++;
    drive(1'b1, 3'b001, 3'b000, 11'd4, 5'd4, 5'd0, 5'd0);
    #1;
    total++; if (id_illegal !== 1'b1) $display("FAIL ill_b_f11 got=%0h exp=1", id_illegal); else passed++;
    drive(1'b1, 3'b011, 3'b011, 11'd0, 5'd4, 5'd0, 5'd0);
    #1;
    total++; if (id_illegal !== 1'b1) $display("FAIL ill_d_f3 got=%0h exp=1", id_illegal); else passed++;
    drive(1'b0, 3'b111, 3'b000, 11'd0, 5'd4, 5'd0, 5'd0);
    #1;
    total++; if (id_illegal !== 1'b0) $display("FAIL ill_novalid got=%0h exp=0", id_illegal); else passed++;
    tick();
    drive(1'b1, 3'b110, 3'b101, 11'd0, 5'd0, 5'd1, 5'd2);
    tick();
    total++; if (ex_jump_cond !== 1'b1) $display("FAIL g_jcond got=%0h exp=1", ex_jump_cond); else passed++;
    total++; if (ex_jump_cond_type !== 3'b101) $display("FAIL g_jtype got=%0h exp=5", ex_jump_cond_type); else passed++;
    total++; if (ex_alu_control !== 4'b0001) $display("FAIL g_alu got=%0h exp=1", ex_alu_control); else passed++;
    total++; if (ex_reg_write !== 1'b0) $display("FAIL g_regw got=%0h exp=0", ex_reg_write); else passed++;
    drive(1'b1, 3'b011, 3'b010, 11'd0, 5'd9, 5'd0, 5'd0);
    tick();
    total++; if (ex_jump !== 1'b1) $display("FAIL d_jump got=%0h exp=1", ex_jump); else passed++;
    total++; if (ex_imm_src !== 4'b1100) $display("FAIL d_imm got=%0h exp=c", ex_imm_src); else passed++;
    total++; if (ex_result_src !== 2'b10) $display("FAIL d_res got=%0h exp=2", ex_result_src); else passed++;
  endtask

  task automatic test_hold_reset();
    drive(1'b1, 3'b001, 3'b100, 11'd0, 5'd9, 5'd2, 5'd0);
    tick();
    drive(1'b1, 3'b000, 3'b000, 11'd0, 5'd10, 5'd1, 5'd1);
    ex_hold = 1'b1;
    #1;
    total++; if (id_stall !== 1'b1) $display("FAIL hold_stall got=%0h exp=1", id_stall); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (ex_valid !== 1'b1) $display("FAIL hold_valid got=%0h exp=1", ex_valid); else passed++;
      total++; if (ex_rd !== 5'd9) $display("FAIL hold_rd got=%0d exp=9", ex_rd); else passed++;
      total++; if (ex_alu_control !== 4'b0100) $display("FAIL hold_alu got=%0h exp=4", ex_alu_control); else passed++;
      total++; if (ex_imm_src !== 4'b0010) $display("FAIL hold_imm got=%0h exp=2", ex_imm_src); else passed++;
      total++; if (ex_alu_src !== 1'b1) $display("FAIL hold_alusrc got=%0h exp=1", ex_alu_src); else passed++;
    end
    #2 rst = 1'b1;
    #1;
    total++; if (ex_valid !== 1'b0) $display("FAIL arst_valid got=%0h exp=0", ex_valid); else passed++;
    total++; if (ex_rd !== 5'd0) $display("FAIL arst_rd got=%0d exp=0", ex_rd); else passed++;
    total++; if (ex_alu_control !== 4'd0) $display("FAIL arst_alu got=%0h exp=0", ex_alu_control); else passed++;
    total++; if (stall_count !== 4'd0) $display("FAIL arst_stall_cnt got=%0d exp=0", stall_count); else passed++;
    total++; if (flush_count !== 4'd0) $display("FAIL arst_flush_cnt got=%0d exp=0", flush_count); else passed++;
    ex_hold = 1'b0;
    drive(1'b0, 3'b000, 3'b000, 11'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clk); rst = 1'b0;
    tick();
  endtask

  task automatic test_flush_saturate();
    ex_flush = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    total++; if (flush_count !== 4'hF) $display("FAIL sat_reach got=%0h exp=f", flush_count); else passed++;
    tick(); tick();
    total++; if (flush_count !== 4'hF) $display("FAIL sat_hold got=%0h exp=f", flush_count); else passed++;
    ex_flush = 1'b0;
    tick();
    total++; if (flush_count !== 4'hF) $display("FAIL sat_idle got=%0h exp=f", flush_count); else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_use();
    test_rd_zero();
    test_flush_hazard();
    test_ext_illegal();
    test_hold_reset();
    test_flush_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
